// File: rtl/mem_access_ctrl_if.sv
// Load/store request, memory bus and response signals of mem_access_ctrl.
// slave is the controller's view; master is the pipeline plus memory environment.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_offset;
    logic [1:0]  rsp_size;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata,
        output rsp_valid, rsp_rdata, rsp_offset, rsp_size, rsp_err
    );

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata,
        input  rsp_valid, rsp_rdata, rsp_offset, rsp_size, rsp_err
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller: aligns requests onto a word bus,
// aborts after TIMEOUT unacknowledged cycles and returns a one-cycle response.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_ctrl_if.slave  bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  wait_cnt;
    logic [1:0]  lat_offset;
    logic [1:0]  lat_size;

    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;

    logic [31:0] rsp_rdata_q;
    logic [1:0]  rsp_offset_q;
    logic [1:0]  rsp_size_q;
    logic        rsp_err_q;

    logic [1:0]  req_off;
    logic        req_bad;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    assign req_off = bus.req_addr[1:0];

    // Misaligned or illegal-size requests never reach the memory bus.
    always_comb begin
        req_bad    = 1'b0;
        be_next    = 4'b1111;
        wdata_next = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                be_next    = 4'b0001 << req_off;
                wdata_next = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                req_bad    = req_off[0];
                be_next    = 4'b0011 << req_off;
                wdata_next = {2{bus.req_wdata[15:0]}};
            end
            2'b10: req_bad = |req_off;
            default: req_bad = 1'b1;
        endcase
        if (!bus.req_write) be_next = 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= 8'd0;
            lat_offset   <= 2'b00;
            lat_size     <= 2'b00;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_be_q     <= 4'b0000;
            mem_wdata_q  <= 32'd0;
            rsp_rdata_q  <= 32'd0;
            rsp_offset_q <= 2'b00;
            rsp_size_q   <= 2'b00;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (req_bad) begin
                            state        <= RESP;
                            rsp_err_q    <= 1'b1;
                            rsp_offset_q <= req_off;
                            rsp_size_q   <= bus.req_size;
                        end else begin
                            state       <= ACCESS;
                            wait_cnt    <= 8'd0;
                            lat_offset  <= req_off;
                            lat_size    <= bus.req_size;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= bus.req_write;
                            mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
                            mem_be_q    <= be_next;
                            mem_wdata_q <= wdata_next;
                        end
                    end
                end
                // An ack in the cycle the wait budget runs out still completes normally.
                ACCESS: begin
                    if (bus.mem_ack) begin
                        state        <= RESP;
                        mem_req_q    <= 1'b0;
                        rsp_err_q    <= 1'b0;
                        rsp_offset_q <= lat_offset;
                        rsp_size_q   <= lat_size;
                        if (!mem_we_q) rsp_rdata_q <= bus.mem_rdata;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state        <= RESP;
                        mem_req_q    <= 1'b0;
                        rsp_err_q    <= 1'b1;
                        rsp_offset_q <= lat_offset;
                        rsp_size_q   <= lat_size;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.rsp_valid  = (state == RESP);
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_offset = rsp_offset_q;
    assign bus.rsp_size   = rsp_size_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a transaction-level reference model is
// checked against the DUT every cycle, plus literal checks at key points.
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int   ack_delay = 0;
    int   ack_cnt   = 0;
    logic stray_ack = 1'b0;
    logic [31:0] mem_img [logic [31:0]];

    bit          m_busy   = 1'b0;
    bit          m_resp   = 1'b0;
    int          m_waited = 0;
    logic        m_we     = 1'b0;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_wdata  = '0;
    logic [3:0]  m_be     = '0;
    logic [1:0]  m_off    = '0;
    logic [1:0]  m_size   = '0;
    logic [1:0]  r_off    = '0;
    logic [1:0]  r_size   = '0;
    logic        r_err    = 1'b0;
    logic [31:0] r_rdata  = '0;
    int          off;
    int          nbytes;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder: acks in the ack_delay-th cycle of mem_req, data looked up by word address.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.mem_req) ack_cnt++;
            else ack_cnt = 0;
            bus.mem_ack   = (ack_delay != 0 && bus.mem_req && ack_cnt == ack_delay) || stray_ack;
            bus.mem_rdata = mem_img.exists(bus.mem_addr) ? mem_img[bus.mem_addr] : 32'hDEAD_BEEF;
        end
    end

    // Reference model: one transaction in flight, response visible for the cycle after it ends.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 1'b0; m_resp = 1'b0; m_waited = 0;
            m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0;
            r_off = '0; r_size = '0; r_err = 1'b0; r_rdata = '0;
        end else if (m_resp) begin
            m_resp = 1'b0;
        end else if (m_busy) begin
            m_waited++;
            if (bus.mem_ack || m_waited == TIMEOUT) begin
                if (bus.mem_ack && !m_we) r_rdata = bus.mem_rdata;
                r_err  = !bus.mem_ack;
                r_off  = m_off;
                r_size = m_size;
                m_busy = 1'b0;
                m_resp = 1'b1;
            end
        end else if (bus.req_valid) begin
            off    = int'(bus.req_addr % 32'd4);
            nbytes = (bus.req_size == 2'b11) ? 0 : (1 << bus.req_size);
            m_off  = bus.req_addr[1:0];
            m_size = bus.req_size;
            if (nbytes == 0 || off % nbytes != 0) begin
                r_err  = 1'b1;
                r_off  = m_off;
                r_size = m_size;
                m_resp = 1'b1;
            end else begin
                m_busy   = 1'b1;
                m_waited = 0;
                m_we     = bus.req_write;
                m_addr   = bus.req_addr - 32'(off);
                m_be     = '0;
                for (int i = 0; i < 4; i++)
                    if (bus.req_write && i >= off && i < off + nbytes) m_be[i] = 1'b1;
                m_wdata  = (nbytes == 1) ? 32'h0101_0101 * {24'b0, bus.req_wdata[7:0]} :
                           (nbytes == 2) ? 32'h0001_0001 * {16'b0, bus.req_wdata[15:0]} :
                                           bus.req_wdata;
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            checkOutput("req_ready", 32'(bus.req_ready), 32'(!m_busy && !m_resp));
            checkOutput("mem_req", 32'(bus.mem_req), 32'(m_busy));
            checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(m_resp));
            checkOutput("rsp_offset", 32'(bus.rsp_offset), 32'(r_off));
            checkOutput("rsp_size", 32'(bus.rsp_size), 32'(r_size));
            checkOutput("rsp_err", 32'(bus.rsp_err), 32'(r_err));
            checkOutput("rsp_rdata", bus.rsp_rdata, r_rdata);
            if (m_busy || !rst_n) begin
                checkOutput("mem_we", 32'(bus.mem_we), 32'(m_we));
                checkOutput("mem_addr", bus.mem_addr, m_addr);
                checkOutput("mem_be", 32'(bus.mem_be), 32'(m_be));
                if (m_we || !rst_n) checkOutput("mem_wdata", bus.mem_wdata, m_wdata);
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                                 input logic [31:0] wd, input int delay);
        bit ok = 1'b0;
        ack_delay     = delay;
        bus.req_write = wr;
        bus.req_size  = sz;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        bus.req_valid = 1'b0;
        checkOutput("accept", 32'(ok), 32'd1);
    endtask

    task automatic waitResponse(output int at, output int req_cycles);
        at = -1;
        req_cycles = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                at = cyc;
                break;
            end
            if (bus.mem_req) req_cycles++;
        end
        checkOutput("rsp_arrived", 32'(at >= 0), 32'd1);
    endtask

    logic [31:0] err_addr [3] = '{32'h3001, 32'h3003, 32'h3000};
    logic [1:0]  err_size [3] = '{2'b10, 2'b01, 2'b11};
    logic        err_wr   [3] = '{1'b0, 1'b0, 1'b1};

    initial begin
        int acc, at, at1, nreq, seen;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size  = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        mem_img[32'h1000] = 32'hAABB_CCDD;
        mem_img[32'h6004] = 32'h600D_600D;
        mem_img[32'h7000] = 32'h1122_3344;
        mem_img[32'h8000] = 32'hCAFE_F00D;
        mem_img[32'h8004] = 32'h0BAD_C0DE;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_mem_req", 32'(bus.mem_req), 32'd0);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] load byte 0x1003");
        applyStimulus(1'b0, 2'b00, 32'h1003, 32'h0, 2);
        acc = cyc;
        @(negedge clk);
        checkOutput("ld_mem_req", 32'(bus.mem_req), 32'd1);
        checkOutput("ld_mem_addr", bus.mem_addr, 32'h1000);
        checkOutput("ld_mem_be", 32'(bus.mem_be), 32'd0);
        waitResponse(at, nreq);
        checkOutput("ld_latency", 32'(at - acc), 32'd2);
        checkOutput("ld_rdata", bus.rsp_rdata, 32'hAABB_CCDD);
        checkOutput("ld_offset", 32'(bus.rsp_offset), 32'd3);
        checkOutput("ld_size", 32'(bus.rsp_size), 32'd0);
        checkOutput("ld_err", 32'(bus.rsp_err), 32'd0);

        $display("[TB] store half 0x2002, store byte 0x4001");
        applyStimulus(1'b1, 2'b01, 32'h2002, 32'h0000_1234, 1);
        acc = cyc;
        @(negedge clk);
        checkOutput("sth_mem_we", 32'(bus.mem_we), 32'd1);
        checkOutput("sth_mem_be", 32'(bus.mem_be), 32'hC);
        checkOutput("sth_mem_wdata", bus.mem_wdata, 32'h1234_1234);
        waitResponse(at, nreq);
        checkOutput("sth_latency", 32'(at - acc), 32'd1);
        checkOutput("sth_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("sth_rdata_kept", bus.rsp_rdata, 32'hAABB_CCDD);
        applyStimulus(1'b1, 2'b00, 32'h4001, 32'h0000_00AB, 3);
        @(negedge clk);
        checkOutput("stb_mem_be", 32'(bus.mem_be), 32'h2);
        checkOutput("stb_mem_wdata", bus.mem_wdata, 32'hABAB_ABAB);
        waitResponse(at, nreq);

        $display("[TB] misaligned and illegal-size requests");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(err_wr[k], err_size[k], err_addr[k], 32'h5555_5555, 1);
            acc = cyc;
            waitResponse(at, nreq);
            checkOutput("err_latency", 32'(at - acc), 32'd0);
            checkOutput("err_no_mem_req", 32'(nreq), 32'd0);
            checkOutput("err_flag", 32'(bus.rsp_err), 32'd1);
        end

        $display("[TB] timeout without ack, then ack in last cycle");
        applyStimulus(1'b0, 2'b10, 32'h6000, 32'h0, 0);
        acc = cyc;
        waitResponse(at, nreq);
        checkOutput("to_req_cycles", 32'(nreq), 32'd4);
        checkOutput("to_err", 32'(bus.rsp_err), 32'd1);
        applyStimulus(1'b0, 2'b10, 32'h6004, 32'h0, 4);
        acc = cyc;
        waitResponse(at, nreq);
        checkOutput("late_ack_req_cycles", 32'(nreq), 32'd4);
        checkOutput("late_ack_latency", 32'(at - acc), 32'd4);
        checkOutput("late_ack_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("late_ack_rdata", bus.rsp_rdata, 32'h600D_600D);

        $display("[TB] reset during access");
        applyStimulus(1'b0, 2'b10, 32'h7000, 32'h0, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mem_req", 32'(bus.mem_req), 32'd0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 stray_ack = 1'b1;
        @(posedge clk);
        #1 stray_ack = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.mem_req) seen++;
        end
        checkOutput("stray_ack_ignored", 32'(seen), 32'd0);
        applyStimulus(1'b0, 2'b01, 32'h7002, 32'h0, 2);
        acc = cyc;
        waitResponse(at, nreq);
        checkOutput("post_rst_latency", 32'(at - acc), 32'd2);
        checkOutput("post_rst_rdata", bus.rsp_rdata, 32'h1122_3344);
        checkOutput("post_rst_offset", 32'(bus.rsp_offset), 32'd2);

        $display("[TB] back-to-back loads");
        applyStimulus(1'b0, 2'b00, 32'h8001, 32'h0, 1);
        waitResponse(at1, nreq);
        checkOutput("b2b_rdata0", bus.rsp_rdata, 32'hCAFE_F00D);
        checkOutput("b2b_offset0", 32'(bus.rsp_offset), 32'd1);
        applyStimulus(1'b0, 2'b01, 32'h8006, 32'h0, 1);
        waitResponse(at, nreq);
        checkOutput("b2b_rdata1", bus.rsp_rdata, 32'h0BAD_C0DE);
        checkOutput("b2b_offset1", 32'(bus.rsp_offset), 32'd2);
        checkOutput("b2b_spacing", 32'(at - at1), 32'd3);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
